// File: rtl/buzzer_scheduler_pkg.sv
// Shared constants for the buzzer scheduler: pattern ids, FSM encoding,
// per-pattern segment counts and ON/OFF segment masks (bit i = segment i ON).
package buzzer_pkg;

   localparam logic [1:0] CLICK = 2'd0;
   localparam logic [1:0] OK    = 2'd1;
   localparam logic [1:0] FAIL  = 2'd2;
   localparam logic [1:0] ALARM = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ON   = 2'd1,
      ST_OFF  = 2'd2
   } state_t;

   localparam logic [2:0] NSEG_CLICK = 3'd2;
   localparam logic [2:0] NSEG_OK    = 3'd6;
   localparam logic [2:0] NSEG_FAIL  = 3'd3;
   localparam logic [2:0] NSEG_ALARM = 3'd2;

   localparam logic [7:0] MASK_CLICK = 8'b0000_0011;
   localparam logic [7:0] MASK_OK    = 8'b0011_1111;
   localparam logic [7:0] MASK_FAIL  = 8'b0000_0101;
   localparam logic [7:0] MASK_ALARM = 8'b0000_0001;

   function automatic logic [2:0] seg_count(input logic [1:0] id);
      case (id)
         CLICK:   return NSEG_CLICK;
         OK:      return NSEG_OK;
         FAIL:    return NSEG_FAIL;
         default: return NSEG_ALARM;
      endcase
   endfunction

   function automatic logic [7:0] on_mask(input logic [1:0] id);
      case (id)
         CLICK:   return MASK_CLICK;
         OK:      return MASK_OK;
         FAIL:    return MASK_FAIL;
         default: return MASK_ALARM;
      endcase
   endfunction

endpackage

// File: rtl/buzzer_scheduler_if.sv
// Request/status bundle between the keypad controller and the buzzer scheduler.
interface buzzer_scheduler_if;
   logic       req_click;
   logic       req_ok;
   logic       req_fail;
   logic       alarm_en;
   logic       buzzer;
   logic       busy;
   logic [1:0] active_id;
   logic       drop;

   modport master (
      output req_click, req_ok, req_fail, alarm_en,
      input  buzzer, busy, active_id, drop
   );

   modport slave (
      input  req_click, req_ok, req_fail, alarm_en,
      output buzzer, busy, active_id, drop
   );
endinterface

// File: rtl/buzzer_scheduler_tone_div.sv
// Half-period counter: pulses toggle on the cycle the count reaches hp-1,
// then wraps to 0. clear restarts the count so a new ON segment starts clean.
module tone_div (
   input  logic        clk,
   input  logic        RSTn,
   input  logic        clear,
   input  logic        en,
   input  logic [16:0] hp,
   output logic        toggle
);

   logic [16:0] cnt;

   assign toggle = en && (cnt == (hp - 17'd1));

   // count while enabled, wrap at terminal count
   always_ff @(posedge clk) begin
      if (!RSTn || clear) begin
         cnt <= '0;
      end else if (toggle) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + 17'd1;
      end
   end

endmodule

// File: rtl/buzzer_scheduler.sv
// Priority scheduler and pattern sequencer for the single keypad-lock buzzer.
//
//  state   | meaning
//  --------+----------------------------------------------
//  IDLE    | nothing playing, buzzer low
//  ON      | tone segment, buzzer toggles every HP cycles
//  OFF     | silent segment, buzzer held low
module buzzer_scheduler
   import buzzer_pkg::*;
#(
   parameter int HP_CLICK = 50_000,
   parameter int HP_OK    = 25_000,
   parameter int HP_FAIL  = 100_000,
   parameter int HP_ALARM = 12_500,
   parameter int SEG      = 5_000_000
) (
   input logic                clk,
   input logic                RSTn,
   buzzer_scheduler_if.slave  bus
);

   localparam logic [31:0] SEG_LAST  = 32'(SEG - 1);
   localparam logic [16:0] HPV_CLICK = 17'(HP_CLICK);
   localparam logic [16:0] HPV_OK    = 17'(HP_OK);
   localparam logic [16:0] HPV_FAIL  = 17'(HP_FAIL);
   localparam logic [16:0] HPV_ALARM = 17'(HP_ALARM);

   state_t      state, state_nx;
   logic [1:0]  pid, pid_nx;
   logic [31:0] seg_cnt, seg_cnt_nx;
   logic [2:0]  seg_idx, seg_idx_nx;
   logic        buzz_q, buzz_nx;
   logic        drop_q, drop_nx;

   logic        busy_i, seg_end, last_end, alarm_play, free;
   logic        any_req, multi_req, start, tone_clr, tone_tgl;
   logic [1:0]  n_req, req_id, start_id;
   logic [2:0]  nxt_idx;
   logic [7:0]  mask_cur;
   logic [16:0] hp_sel;

   assign busy_i     = (state != ST_IDLE);
   assign alarm_play = busy_i && (pid == ALARM);
   assign seg_end    = busy_i && (seg_cnt == SEG_LAST);
   assign last_end   = seg_end && (pid != ALARM) && (seg_idx == (seg_count(pid) - 3'd1));
   // a finishing pattern or a released alarm leaves the slot open this cycle
   assign free       = !busy_i || last_end || (alarm_play && !bus.alarm_en);

   assign n_req     = {1'b0, bus.req_click} + {1'b0, bus.req_ok} + {1'b0, bus.req_fail};
   assign any_req   = (n_req != 2'd0);
   assign multi_req = (n_req > 2'd1);
   assign req_id    = bus.req_fail ? FAIL : (bus.req_ok ? OK : CLICK);

   assign mask_cur = on_mask(pid);
   assign nxt_idx  = (pid == ALARM && seg_idx == 3'd1) ? 3'd0 : seg_idx + 3'd1;

   // half-period of the pattern currently playing
   always_comb begin
      case (pid)
         CLICK:   hp_sel = HPV_CLICK;
         OK:      hp_sel = HPV_OK;
         FAIL:    hp_sel = HPV_FAIL;
         default: hp_sel = HPV_ALARM;
      endcase
   end

   tone_div u_tone_div (
      .clk    (clk),
      .RSTn   (RSTn),
      .clear  (tone_clr),
      .en     (state == ST_ON),
      .hp     (hp_sel),
      .toggle (tone_tgl)
   );

   // arbitration, segment sequencing and buzzer next-value
   always_comb begin
      state_nx   = state;
      pid_nx     = pid;
      seg_cnt_nx = seg_cnt;
      seg_idx_nx = seg_idx;
      buzz_nx    = buzz_q;
      drop_nx    = 1'b0;
      tone_clr   = 1'b0;
      start      = 1'b0;
      start_id   = pid;

      if (bus.alarm_en) begin
         drop_nx = any_req;
         if (!alarm_play) begin
            start    = 1'b1;
            start_id = ALARM;
         end
      end else if (any_req && (free || req_id > pid)) begin
         start    = 1'b1;
         start_id = req_id;
         drop_nx  = multi_req;
      end else begin
         drop_nx = any_req;
      end

      if (start) begin
         state_nx   = ST_ON;
         pid_nx     = start_id;
         seg_idx_nx = '0;
         seg_cnt_nx = '0;
         buzz_nx    = 1'b1;
         tone_clr   = 1'b1;
      end else if (free) begin
         state_nx   = ST_IDLE;
         pid_nx     = CLICK;
         seg_idx_nx = '0;
         seg_cnt_nx = '0;
         buzz_nx    = 1'b0;
      end else if (seg_end) begin
         seg_idx_nx = nxt_idx;
         seg_cnt_nx = '0;
         if (mask_cur[nxt_idx]) begin
            state_nx = ST_ON;
            buzz_nx  = 1'b1;
            tone_clr = 1'b1;
         end else begin
            state_nx = ST_OFF;
            buzz_nx  = 1'b0;
         end
      end else begin
         seg_cnt_nx = seg_cnt + 32'd1;
         if (state == ST_ON && tone_tgl) begin
            buzz_nx = ~buzz_q;
         end
      end
   end

   // state and output registers
   always_ff @(posedge clk) begin
      if (!RSTn) begin
         state   <= ST_IDLE;
         pid     <= CLICK;
         seg_cnt <= '0;
         seg_idx <= '0;
         buzz_q  <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         state   <= state_nx;
         pid     <= pid_nx;
         seg_cnt <= seg_cnt_nx;
         seg_idx <= seg_idx_nx;
         buzz_q  <= buzz_nx;
         drop_q  <= drop_nx;
      end
   end

   assign bus.buzzer    = buzz_q;
   assign bus.busy      = busy_i;
   assign bus.active_id = pid;
   assign bus.drop      = drop_q;

endmodule

// File: tb/tb_buzzer_scheduler.sv
// Directed bench for buzzer_scheduler: each step pushes the expected per-cycle
// outputs into a queue, and every clock one entry is popped and compared.
module tb_buzzer_scheduler;

   localparam int SEG = 20;

   typedef struct packed {
      logic       buzzer;
      logic       busy;
      logic [1:0] id;
      logic       drop;
   } obs_t;

   logic clk = 1'b0;
   logic RSTn;
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   string tag = "init";
   obs_t exp_q[$];

   buzzer_scheduler_if bus ();

   buzzer_scheduler #(
      .HP_CLICK (4),
      .HP_OK    (2),
      .HP_FAIL  (8),
      .HP_ALARM (1),
      .SEG      (SEG)
   ) dut (
      .clk  (clk),
      .RSTn (RSTn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   function automatic int b_hp(input int id);
      case (id)
         0: return 4;
         1: return 2;
         2: return 8;
         default: return 1;
      endcase
   endfunction

   function automatic int b_nseg(input int id);
      case (id)
         0: return 2;
         1: return 6;
         2: return 3;
         default: return 2;
      endcase
   endfunction

   function automatic bit b_on(input int id, input int seg);
      case (id)
         2: return seg != 1;
         3: return seg == 0;
         default: return 1'b1;
      endcase
   endfunction

   task automatic push_pat(input int id, input int n);
      obs_t e;
      int seg, pos;
      for (int k = 0; k < n; k++) begin
         seg = (k / SEG) % b_nseg(id);
         pos = k % SEG;
         e.buzzer = b_on(id, seg) && (((pos / b_hp(id)) % 2) == 0);
         e.busy   = 1'b1;
         e.id     = 2'(id);
         e.drop   = 1'b0;
         exp_q.push_back(e);
      end
   endtask

   task automatic push_idle(input int n);
      for (int k = 0; k < n; k++) exp_q.push_back(obs_t'(5'b0));
   endtask

   task automatic mark_drop(input int idx);
      obs_t e;
      e = exp_q[idx];
      e.drop = 1'b1;
      exp_q[idx] = e;
   endtask

   task automatic tick();
      obs_t o, e;
      @(posedge clk);
      #1;
      bus.req_click = 1'b0;
      bus.req_ok    = 1'b0;
      bus.req_fail  = 1'b0;
      cyc++;
      o = {bus.buzzer, bus.busy, bus.active_id, bus.drop};
      e = (exp_q.size() != 0) ? exp_q.pop_front() : obs_t'('x);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, o, e);
      end
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      RSTn          = 1'b0;
      bus.req_click = 1'b0;
      bus.req_ok    = 1'b0;
      bus.req_fail  = 1'b0;
      bus.alarm_en  = 1'b0;

      tag = "reset";
      push_idle(3); ticks(3);
      RSTn = 1'b1;
      push_idle(5); ticks(5);

      // click: 40 busy cycles, toggles every 4, then idle
      tag = "click";
      bus.req_click = 1'b1;
      push_pat(0, 40); push_idle(3); ticks(43);

      // three simultaneous pulses: fail wins, drop once; repeat fail dropped
      tag = "fail";
      bus.req_click = 1'b1; bus.req_ok = 1'b1; bus.req_fail = 1'b1;
      push_pat(2, 60); mark_drop(0); mark_drop(25);
      ticks(25);
      bus.req_fail = 1'b1;
      ticks(35);
      push_idle(3); ticks(3);

      // click during ok is dropped, ok continues for 120 cycles
      tag = "ok_drop";
      bus.req_ok = 1'b1;
      push_pat(1, 120); mark_drop(30);
      ticks(30);
      bus.req_click = 1'b1;
      ticks(90);
      push_idle(3); ticks(3);

      // fail preempts click at offset 15 with no gap
      tag = "preempt";
      bus.req_click = 1'b1;
      push_pat(0, 15); ticks(15);
      bus.req_fail = 1'b1;
      push_pat(2, 60); push_idle(3); ticks(63);

      // click arriving on the final segment end of a click is accepted
      tag = "end_accept";
      bus.req_click = 1'b1;
      push_pat(0, 40); ticks(40);
      bus.req_click = 1'b1;
      push_pat(0, 40); push_idle(3); ticks(43);

      // alarm preempts ok, ok during alarm dropped, alarm stops next cycle
      tag = "alarm";
      bus.req_ok = 1'b1;
      push_pat(1, 10); ticks(10);
      bus.alarm_en = 1'b1;
      push_pat(3, 100); mark_drop(50);
      ticks(50);
      bus.req_ok = 1'b1;
      ticks(50);
      bus.alarm_en = 1'b0;
      push_idle(3); ticks(3);

      // reset mid-ok clears everything; a later click runs normally
      tag = "mid_reset";
      bus.req_ok = 1'b1;
      push_pat(1, 40); ticks(40);
      RSTn = 1'b0;
      push_idle(2); ticks(2);
      RSTn = 1'b1;
      push_idle(2); ticks(2);
      bus.req_click = 1'b1;
      push_pat(0, 40); push_idle(3); ticks(43);

      checks++;
      assert (exp_q.size() == 0) else begin
         errors++;
         $error("FAIL queue_empty observed=%0d expected=0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
